// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the memory-port arbiter.
// State encoding and grant encoding are shared by the top and its beat counter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WDATA = 2'd2,
      RRESP = 2'd3
   } state_e;

   localparam logic GNT_IC = 1'b0;
   localparam logic GNT_DC = 1'b1;

   // Width of a counter able to index BEATS beats (at least one bit).
   function automatic int cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/mem_arb_beat_counter.sv
// Beat counter for one burst: clear, increment, and a flag on the final beat.
// Wraps to zero after the final beat so it never holds a value beyond BEATS-1.
module mem_arb_beat_counter
   import mem_arb_pkg::*;
#(
   parameter  int BEATS = 4,
   localparam int CW    = cnt_width(BEATS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [CW-1:0] cnt_o,
   output logic          last_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   assign last_o = (cnt_q == CW'(BEATS - 1));
   assign cnt_o  = cnt_q;

   // Next count: clear wins over increment; the final beat wraps to zero.
   always_comb begin
      // NOTE: assign a default first so every path drives cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = last_o ? '0 : cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the off-chip memory port between icache and dcache.
// One transaction at a time; the grant is held across the request handshake
// and every write-data or read-response beat of the burst.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to let a contested grant go to
// the client not served last; otherwise dcache always beats icache.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_BITS = 28,
   parameter int DATA_BITS = 128,
   parameter int BEATS     = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   // icache client
   input  logic                   ic_req_val,
   output logic                   ic_req_rdy,
   input  logic [ADDR_BITS-1:0]   ic_req_addr,
   input  logic                   ic_req_rw,
   input  logic                   ic_req_data_valid,
   output logic                   ic_req_data_ready,
   input  logic [DATA_BITS-1:0]   ic_req_data_bits,
   input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
   output logic                   ic_resp_val,
   // dcache client
   input  logic                   dc_req_val,
   output logic                   dc_req_rdy,
   input  logic [ADDR_BITS-1:0]   dc_req_addr,
   input  logic                   dc_req_rw,
   input  logic                   dc_req_data_valid,
   output logic                   dc_req_data_ready,
   input  logic [DATA_BITS-1:0]   dc_req_data_bits,
   input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
   output logic                   dc_resp_val,
   // shared response data
   output logic [DATA_BITS-1:0]   resp_data,
   // memory side
   output logic                   mem_req_val,
   input  logic                   mem_req_rdy,
   output logic [ADDR_BITS-1:0]   mem_req_addr,
   output logic                   mem_req_rw,
   output logic                   mem_req_data_valid,
   input  logic                   mem_req_data_ready,
   output logic [DATA_BITS-1:0]   mem_req_data_bits,
   output logic [DATA_BITS/8-1:0] mem_req_data_mask,
   input  logic                   mem_resp_val,
   input  logic [DATA_BITS-1:0]   mem_resp_data
);

   localparam int CW = cnt_width(BEATS);

   state_e        state_q, state_d;
   logic          gnt_q, gnt_d;
   logic          gnt_pick;
   logic          cnt_clr, cnt_inc, cnt_last;
   logic [CW-1:0] cnt;
   logic          any_req;
   logic          sel_dc;

   assign any_req = ic_req_val | dc_req_val;
   assign sel_dc  = (gnt_q == GNT_DC);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_gnt_q, last_gnt_d;

   assign gnt_pick = (ic_req_val && dc_req_val) ? ~last_gnt_q
                   : (dc_req_val ? GNT_DC : GNT_IC);

   // Remember whoever was granted on each entry to REQ.
   always_comb begin
      last_gnt_d = last_gnt_q;
      if (state_q == IDLE && any_req) last_gnt_d = gnt_pick;
   end

   // Last-grant register; after reset icache counts as served last.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) last_gnt_q <= GNT_IC;
      else        last_gnt_q <= last_gnt_d;
   end
`else
   assign gnt_pick = dc_req_val ? GNT_DC : GNT_IC;
`endif

   // Address/data muxes follow the latched grant; qualifiers gate them.
   assign mem_req_addr      = sel_dc ? dc_req_addr      : ic_req_addr;
   assign mem_req_rw        = sel_dc ? dc_req_rw        : ic_req_rw;
   assign mem_req_data_bits = sel_dc ? dc_req_data_bits : ic_req_data_bits;
   assign mem_req_data_mask = sel_dc ? dc_req_data_mask : ic_req_data_mask;
   assign resp_data         = mem_resp_data;

   mem_arb_beat_counter #(.BEATS(BEATS)) u_beat_cnt (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .cnt_o  (cnt),
      .last_o (cnt_last)
   );

   // Next-state, grant latch and handshake routing.
   always_comb begin
      state_d            = state_q;
      gnt_d              = gnt_q;
      cnt_clr            = 1'b0;
      cnt_inc            = 1'b0;
      mem_req_val        = 1'b0;
      mem_req_data_valid = 1'b0;
      ic_req_rdy         = 1'b0;
      dc_req_rdy         = 1'b0;
      ic_req_data_ready  = 1'b0;
      dc_req_data_ready  = 1'b0;
      ic_resp_val        = 1'b0;
      dc_resp_val        = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt_d   = gnt_pick;
               state_d = REQ;
            end
         end
         REQ: begin
            mem_req_val = 1'b1;
            ic_req_rdy  = !sel_dc && mem_req_rdy;
            dc_req_rdy  =  sel_dc && mem_req_rdy;
            if (mem_req_rdy) begin
               cnt_clr = 1'b1;
               state_d = mem_req_rw ? WDATA : RRESP;
            end
         end
         WDATA: begin
            mem_req_data_valid = sel_dc ? dc_req_data_valid : ic_req_data_valid;
            ic_req_data_ready  = !sel_dc && mem_req_data_ready;
            dc_req_data_ready  =  sel_dc && mem_req_data_ready;
            if (mem_req_data_valid && mem_req_data_ready) begin
               if (cnt_last) begin
                  cnt_clr = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         RRESP: begin
            ic_resp_val = !sel_dc && mem_resp_val;
            dc_resp_val =  sel_dc && mem_resp_val;
            if (mem_resp_val) begin
               cnt_inc = 1'b1;
               if (cnt_last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and grant registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         gnt_q   <= GNT_IC;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
      end
   end

   // The granted client must keep req_val up until its request is accepted.
   a_req_held : assert property (@(posedge clk) disable iff (!reset)
      (state_q == REQ) |-> (sel_dc ? dc_req_val : ic_req_val));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Inputs are driven 1 time unit after the rising edge, outputs checked 1 unit later.
module tb_mem_arbiter;

   localparam int AB = 28;
   localparam int DB = 128;

   logic          clk = 1'b0;
   logic          reset;
   logic          ic_req_val, ic_req_rdy, ic_req_rw, ic_req_data_valid, ic_req_data_ready, ic_resp_val;
   logic [AB-1:0] ic_req_addr;
   logic [DB-1:0] ic_req_data_bits;
   logic [DB/8-1:0] ic_req_data_mask;
   logic          dc_req_val, dc_req_rdy, dc_req_rw, dc_req_data_valid, dc_req_data_ready, dc_resp_val;
   logic [AB-1:0] dc_req_addr;
   logic [DB-1:0] dc_req_data_bits;
   logic [DB/8-1:0] dc_req_data_mask;
   logic [DB-1:0] resp_data;
   logic          mem_req_val, mem_req_rdy, mem_req_rw, mem_req_data_valid, mem_req_data_ready, mem_resp_val;
   logic [AB-1:0] mem_req_addr;
   logic [DB-1:0] mem_req_data_bits, mem_resp_data;
   logic [DB/8-1:0] mem_req_data_mask;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .BEATS(4)) dut (
      .clk(clk), .reset(reset),
      .ic_req_val(ic_req_val), .ic_req_rdy(ic_req_rdy), .ic_req_addr(ic_req_addr),
      .ic_req_rw(ic_req_rw), .ic_req_data_valid(ic_req_data_valid),
      .ic_req_data_ready(ic_req_data_ready), .ic_req_data_bits(ic_req_data_bits),
      .ic_req_data_mask(ic_req_data_mask), .ic_resp_val(ic_resp_val),
      .dc_req_val(dc_req_val), .dc_req_rdy(dc_req_rdy), .dc_req_addr(dc_req_addr),
      .dc_req_rw(dc_req_rw), .dc_req_data_valid(dc_req_data_valid),
      .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
      .dc_req_data_mask(dc_req_data_mask), .dc_resp_val(dc_resp_val),
      .resp_data(resp_data),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
      .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
      .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
      .mem_req_data_mask(mem_req_data_mask), .mem_resp_val(mem_resp_val),
      .mem_resp_data(mem_resp_data)
   );

   task automatic check(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ":mem_req_val"}, mem_req_val, 0);
      check({tag, ":mem_wvalid"}, mem_req_data_valid, 0);
      check({tag, ":ic_rdy"}, ic_req_rdy, 0);
      check({tag, ":dc_rdy"}, dc_req_rdy, 0);
      check({tag, ":ic_wrdy"}, ic_req_data_ready, 0);
      check({tag, ":dc_wrdy"}, dc_req_data_ready, 0);
      check({tag, ":ic_resp"}, ic_resp_val, 0);
      check({tag, ":dc_resp"}, dc_resp_val, 0);
   endtask

   // Reset pulse applied mid-cycle; outputs must be idle during and right after it.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      check_quiet({tag, ":in_reset"});
      tick();
      tick();
      reset = 1'b1;
      #1;
      check_quiet({tag, ":after_reset"});
   endtask

   // Full 4-beat read for one client, starting in an IDLE cycle.
   task automatic read_txn(input bit dc, input logic [AB-1:0] addr,
                           input logic [DB-1:0] base, input string tag);
      if (dc) begin dc_req_val = 1'b1; dc_req_addr = addr; dc_req_rw = 1'b0; end
      else    begin ic_req_val = 1'b1; ic_req_addr = addr; ic_req_rw = 1'b0; end
      mem_req_rdy = 1'b1;
      #1;
      check({tag, ":idle_val"}, mem_req_val, 0);
      tick();
      check({tag, ":req_val"}, mem_req_val, 1);
      check({tag, ":addr"}, mem_req_addr, addr);
      check({tag, ":rw"}, mem_req_rw, 0);
      check({tag, ":own_rdy"}, dc ? dc_req_rdy : ic_req_rdy, 1);
      check({tag, ":oth_rdy"}, dc ? ic_req_rdy : dc_req_rdy, 0);
      tick();
      if (dc) dc_req_val = 1'b0; else ic_req_val = 1'b0;
      for (int b = 0; b < 4; b++) begin
         mem_resp_val  = 1'b1;
         mem_resp_data = base + DB'(b);
         #1;
         check($sformatf("%s:own_resp%0d", tag, b), dc ? dc_resp_val : ic_resp_val, 1);
         check($sformatf("%s:oth_resp%0d", tag, b), dc ? ic_resp_val : dc_resp_val, 0);
         check($sformatf("%s:data%0d", tag, b), resp_data, base + DB'(b));
         tick();
      end
      // A fifth beat must be ignored: the burst is over.
      mem_resp_data = base + DB'(4);
      #1;
      check({tag, ":extra_ic"}, ic_resp_val, 0);
      check({tag, ":extra_dc"}, dc_resp_val, 0);
      check({tag, ":end_idle"}, mem_req_val, 0);
      mem_resp_val = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          rdy_pat [5];
      logic        exp_g [3];
      int          beat;
      rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_g = '{1'b1, 1'b0, 1'b1};
`else
      exp_g = '{1'b1, 1'b1, 1'b1};
`endif
      reset = 1'b0;
      {ic_req_val, ic_req_rw, ic_req_data_valid} = '0;
      {dc_req_val, dc_req_rw, dc_req_data_valid} = '0;
      ic_req_addr = '0; ic_req_data_bits = '0; ic_req_data_mask = '0;
      dc_req_addr = '0; dc_req_data_bits = '0; dc_req_data_mask = '0;
      mem_req_rdy = 1'b0; mem_req_data_ready = 1'b0;
      mem_resp_val = 1'b0; mem_resp_data = '0;
      #3;
      check_quiet("por");
      tick();
      do_reset("rst0");

      // 1: icache read
      read_txn(1'b0, 28'h0000123, 128'hA0, "t1");

      // 2: dcache write, data_ready pattern 1,0,1,1,1
      dc_req_val = 1'b1; dc_req_addr = 28'h0ABCDEF; dc_req_rw = 1'b1;
      mem_req_rdy = 1'b1;
      tick();
      check("t2:req_val", mem_req_val, 1);
      check("t2:addr", mem_req_addr, 28'h0ABCDEF);
      check("t2:rw", mem_req_rw, 1);
      check("t2:dc_rdy", dc_req_rdy, 1);
      tick();
      dc_req_val = 1'b0;
      dc_req_data_valid = 1'b1;
      dc_req_data_mask  = 16'hFFFF;
      beat = 0;
      for (int i = 0; i < 5; i++) begin
         mem_req_data_ready = rdy_pat[i];
         dc_req_data_bits   = 128'hB0 + DB'(beat);
         #1;
         check($sformatf("t2:wvalid%0d", i), mem_req_data_valid, 1);
         check($sformatf("t2:dc_wrdy%0d", i), dc_req_data_ready, rdy_pat[i]);
         check($sformatf("t2:ic_wrdy%0d", i), ic_req_data_ready, 0);
         check($sformatf("t2:bits%0d", i), mem_req_data_bits, 128'hB0 + DB'(beat));
         check($sformatf("t2:mask%0d", i), mem_req_data_mask, 16'hFFFF);
         if (rdy_pat[i]) beat++;
         tick();
      end
      dc_req_data_bits = 128'hB4;
      #1;
      check("t2:done_wvalid", mem_req_data_valid, 0);
      check("t2:done_wrdy", dc_req_data_ready, 0);
      dc_req_data_valid = 1'b0;
      mem_req_data_ready = 1'b0;
      tick();

      // 3: simultaneous requests after reset; dcache first, then icache
      do_reset("rst3");
      ic_req_val = 1'b1; ic_req_addr = 28'h0000111; ic_req_rw = 1'b0;
      read_txn(1'b1, 28'h0000222, 128'h30, "t3dc");
      read_txn(1'b0, 28'h0000111, 128'h40, "t3ic");
      tick();

      // 4: three contested arbitrations with both clients always requesting
      do_reset("rst4");
      ic_req_val = 1'b1; ic_req_addr = 28'h0000111; ic_req_rw = 1'b0;
      dc_req_val = 1'b1; dc_req_addr = 28'h0000222; dc_req_rw = 1'b0;
      mem_req_rdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("t4:dc_rdy%0d", k), dc_req_rdy, exp_g[k]);
         check($sformatf("t4:ic_rdy%0d", k), ic_req_rdy, !exp_g[k]);
         check($sformatf("t4:addr%0d", k), mem_req_addr, exp_g[k] ? 28'h0000222 : 28'h0000111);
         tick();
         for (int b = 0; b < 4; b++) begin
            mem_resp_val  = 1'b1;
            mem_resp_data = 128'h50 + DB'(b);
            #1;
            check($sformatf("t4:dc_resp%0d_%0d", k, b), dc_resp_val, exp_g[k]);
            check($sformatf("t4:ic_resp%0d_%0d", k, b), ic_resp_val, !exp_g[k]);
            tick();
         end
         mem_resp_val = 1'b0;
      end
      ic_req_val = 1'b0;
      dc_req_val = 1'b0;
      tick();
      tick();

      // 5: reset during RRESP after two beats, then a clean read
      ic_req_val = 1'b1; ic_req_addr = 28'h0000345; ic_req_rw = 1'b0;
      tick();
      check("t5:req_val", mem_req_val, 1);
      tick();
      ic_req_val = 1'b0;
      for (int b = 0; b < 2; b++) begin
         mem_resp_val = 1'b1;
         mem_resp_data = 128'h60 + DB'(b);
         #1;
         check($sformatf("t5:ic_resp%0d", b), ic_resp_val, 1);
         tick();
      end
      mem_resp_data = 128'h62;
      do_reset("t5rst");
      check("t5:post_ic_resp", ic_resp_val, 0);
      mem_resp_val = 1'b0;
      tick();
      read_txn(1'b0, 28'h0000345, 128'hC0, "t5ic");
      tick();

      // 6: stray response in IDLE is dropped
      mem_resp_val = 1'b1;
      mem_resp_data = 128'hDEAD;
      #1;
      check("t6:ic_resp_a", ic_resp_val, 0);
      check("t6:dc_resp_a", dc_resp_val, 0);
      tick();
      check("t6:ic_resp_b", ic_resp_val, 0);
      check("t6:dc_resp_b", dc_resp_val, 0);
      mem_resp_val = 1'b0;
      read_txn(1'b1, 28'h0000456, 128'hD0, "t6dc");
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
